// File: rtl/led_matrix_scan_pkg.sv
// Shared register-map constants for the LED matrix scan driver.
package led_pkg;
    typedef logic [31:0] word_t;

    localparam int CTRL_OFS   = 0;
    localparam int STATUS_OFS = 1;
    localparam int ROW_BASE   = 2;

    localparam int EN_BIT     = 0;
    localparam int DBUF_BIT   = 1;
    localparam int BLINK_LSB  = 8;
    localparam int BLINK_MSB  = 15;
    localparam int BRIGHT_LSB = 16;

    localparam int ST_PEND_BIT      = 0;
    localparam int ST_BLINK_OFF_BIT = 1;
    localparam int ST_ROW_LSB       = 8;
    localparam int ST_FRAME_LSB     = 16;

    // Writable CTRL bits; everything else stores and reads as 0.
    function automatic word_t ctrl_mask(int pwm_bits);
        word_t m;
        m = '0;
        m[EN_BIT]              = 1'b1;
        m[DBUF_BIT]            = 1'b1;
        m[BLINK_MSB:BLINK_LSB] = '1;
        for (int i = 0; i < pwm_bits; i++) m[BRIGHT_LSB + i] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/led_matrix_scan_if.sv
// Register bus between a CPU-side wrapper and the LED matrix scan driver.
interface led_matrix_scan_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       write_data;
    logic              write_en;
    logic [31:0]       read_data;

    modport master (output addr_i, write_data, write_en, input read_data);
    modport slave  (input addr_i, write_data, write_en, output read_data);
endinterface

// File: rtl/led_matrix_scan_timer.sv
// Prescaler -> PWM counter -> row counter chain; everything held at 0 while en is low.
module led_scan_timer #(
    parameter int ROWS     = 8,
    parameter int PWM_BITS = 4,
    parameter int SCAN_DIV = 1000,
    parameter int ROW_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic [ROW_W-1:0]    row,
    output logic                frame_end
);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0] presc_q;
    logic             presc_wrap;
    logic             pwm_wrap;
    logic             row_last;

    assign presc_wrap = (presc_q == PRE_W'(SCAN_DIV - 1));
    assign pwm_wrap   = (pwm_cnt == '1);
    assign row_last   = (row == ROW_W'(ROWS - 1));
    assign tick       = en && presc_wrap;
    assign frame_end  = tick && pwm_wrap && row_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            pwm_cnt <= '0;
            row     <= '0;
        end else if (!en) begin
            presc_q <= '0;
            pwm_cnt <= '0;
            row     <= '0;
        end else begin
            presc_q <= presc_wrap ? '0 : presc_q + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (pwm_wrap) row <= row_last ? '0 : row + ROW_W'(1);
            end
        end
    end
endmodule

// File: rtl/led_matrix_scan.sv
// LED matrix scan driver: register file, double-buffered row data, blink and
// registered row/column drive on top of the scan timer.
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 4,
    parameter int SCAN_DIV = 1000,
    parameter int ADDR_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    led_matrix_scan_if.slave bus,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_out,
    output logic             frame_tick
);
    localparam int    ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam word_t CTRL_MASK = ctrl_mask(PWM_BITS);

    word_t            ctrl_q;
    logic [COLS-1:0]  back_q  [ROWS];
    logic [COLS-1:0]  front_q [ROWS];
    logic             pend_q;
    logic             blink_off_q;
    logic [7:0]       blink_cnt_q;
    logic [15:0]      frame_cnt_q;

    logic                en, dbuf;
    logic [7:0]          blink;
    logic [PWM_BITS-1:0] bright;
    logic                tick, frame_end, frame_evt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [ROW_W-1:0]    row;

    word_t            addr_ext;
    logic             ctrl_we, row_hit, row_we;
    logic [ROW_W-1:0] row_idx;
    word_t            rd;

    assign en     = ctrl_q[EN_BIT];
    assign dbuf   = ctrl_q[DBUF_BIT];
    assign blink  = ctrl_q[BLINK_MSB:BLINK_LSB];
    assign bright = ctrl_q[BRIGHT_LSB +: PWM_BITS];

    led_scan_timer #(
        .ROWS(ROWS), .PWM_BITS(PWM_BITS), .SCAN_DIV(SCAN_DIV), .ROW_W(ROW_W)
    ) u_timer (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .pwm_cnt(pwm_cnt), .row(row), .frame_end(frame_end)
    );

    assign frame_evt = tick && frame_end;

    assign addr_ext = {{(32 - ADDR_W){1'b0}}, bus.addr_i};
    assign ctrl_we  = bus.write_en && (addr_ext == CTRL_OFS);
    assign row_hit  = (addr_ext >= ROW_BASE) && (addr_ext < ROW_BASE + ROWS);
    assign row_we   = bus.write_en && row_hit;
    assign row_idx  = ROW_W'(addr_ext - ROW_BASE);

    always_comb begin
        rd = '0;
        if (addr_ext == CTRL_OFS) begin
            rd = ctrl_q;
        end else if (addr_ext == STATUS_OFS) begin
            rd[ST_PEND_BIT]          = pend_q;
            rd[ST_BLINK_OFF_BIT]     = blink_off_q;
            rd[ST_ROW_LSB +: 8]      = 8'(row);
            rd[ST_FRAME_LSB +: 16]   = frame_cnt_q;
        end else if (row_hit) begin
            rd[COLS-1:0] = back_q[row_idx];
        end
    end
    assign bus.read_data = rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            if (ctrl_we) ctrl_q <= bus.write_data & CTRL_MASK;
            if (row_we) back_q[row_idx] <= bus.write_data[COLS-1:0];
            // The frame-end copy samples back_q before a same-cycle write lands,
            // so that write keeps PEND set and shows up one frame later.
            if (!dbuf) begin
                front_q <= back_q;
                pend_q  <= 1'b0;
            end else begin
                if (frame_evt && pend_q) begin
                    front_q <= back_q;
                    pend_q  <= 1'b0;
                end
                if (row_we) pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            row_sel     <= '0;
            col_out     <= '0;
            frame_tick  <= 1'b0;
        end else begin
            if (frame_evt) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (!en || blink == 8'd0) begin
                blink_cnt_q <= '0;
                blink_off_q <= 1'b0;
            end else if (frame_evt) begin
                if (blink_cnt_q >= blink - 8'd1) begin
                    blink_cnt_q <= '0;
                    blink_off_q <= ~blink_off_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end
            row_sel    <= en ? (ROWS'(1) << row) : '0;
            col_out    <= (en && (pwm_cnt < bright) && !blink_off_q) ? front_q[row] : '0;
            frame_tick <= frame_evt;
        end
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: randomized register traffic against a
// phase-arithmetic reference model of scan position, buffers and blink.
module tb_led_matrix_scan;
    localparam int ROWS     = 4;
    localparam int COLS     = 8;
    localparam int PWM_BITS = 2;
    localparam int SCAN_DIV = 2;
    localparam int ADDR_W   = 4;
    localparam int DWELL    = SCAN_DIV * (1 << PWM_BITS);
    localparam int FRAME    = DWELL * ROWS;
    localparam logic [31:0] CTRL_WMASK = 32'h0003_FF03;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_out;
    logic            frame_tick;

    led_matrix_scan_if #(.ADDR_W(ADDR_W)) bus ();

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWM_BITS), .SCAN_DIV(SCAN_DIV), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .row_sel(row_sel), .col_out(col_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]     m_ctrl;
    logic [COLS-1:0] m_back  [ROWS];
    logic [COLS-1:0] m_front [ROWS];
    bit              m_pend, m_boff;
    int              m_bcnt;
    logic [15:0]     m_frames;
    int              m_phase;
    logic [ROWS-1:0] e_row_sel;
    logic [COLS-1:0] e_col_out;
    logic            e_ftick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_pend = 0; m_boff = 0; m_bcnt = 0; m_frames = '0; m_phase = 0;
        for (int i = 0; i < ROWS; i++) begin m_back[i] = '0; m_front[i] = '0; end
        e_row_sel = '0; e_col_out = '0; e_ftick = 1'b0;
    endtask

    function automatic int cur_row();
        return (m_phase / DWELL) % ROWS;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [7:0] r;
        r = 8'(cur_row());
        if (a == 0) return m_ctrl;
        if (a == 1) return {m_frames, r, 6'b0, m_boff, m_pend};
        if (a >= 2 && a < 2 + ROWS) return {24'b0, m_back[a-2]};
        return 32'h0;
    endfunction

    // One clock edge of the reference: scan position is pure arithmetic on the
    // number of enabled cycles since the last (re)start.
    task automatic model_step(input int a, input logic [31:0] d, input bit we);
        bit en, dbuf, fend;
        int bl, br, row, pwm;
        en   = m_ctrl[0];
        dbuf = m_ctrl[1];
        bl   = int'(m_ctrl[15:8]);
        br   = int'(m_ctrl[17:16]);
        row  = cur_row();
        pwm  = (m_phase / SCAN_DIV) % (1 << PWM_BITS);
        fend = en && ((m_phase % FRAME) == FRAME - 1);

        e_row_sel = en ? ROWS'(1 << row) : '0;
        e_col_out = (en && pwm < br && !m_boff) ? m_front[row] : '0;
        e_ftick   = fend;
        if (fend) m_frames = m_frames + 16'd1;

        if (!en || bl == 0) begin m_bcnt = 0; m_boff = 0; end
        else if (fend) begin
            if (m_bcnt >= bl - 1) begin m_bcnt = 0; m_boff = !m_boff; end
            else m_bcnt++;
        end

        if (!dbuf) begin m_front = m_back; m_pend = 0; end
        else if (fend && m_pend) begin m_front = m_back; m_pend = 0; end

        if (we && a >= 2 && a < 2 + ROWS) begin
            if (dbuf) m_pend = 1;
            m_back[a-2] = d[COLS-1:0];
        end
        if (we && a == 0) m_ctrl = d & CTRL_WMASK;
        m_phase = en ? m_phase + 1 : 0;
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic cyc(input int a, input logic [31:0] d, input bit we);
        bus.addr_i = ADDR_W'(a); bus.write_data = d; bus.write_en = we;
        #1;
        chk("read_data", bus.read_data, model_read(a));
        @(posedge clk);
        model_step(a, d, we);
        @(negedge clk);
        chk("row_sel", 32'(row_sel), 32'(e_row_sel));
        chk("col_out", 32'(col_out), 32'(e_col_out));
        chk("frame_tick", 32'(frame_tick), 32'(e_ftick));
        bus.write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(int'($urandom_range(0, 15)), $urandom, 1'b0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cyc(a, d, 1'b1);
    endtask

    task automatic peek(input string tag, input int a, input logic [31:0] exp);
        bus.addr_i = ADDR_W'(a); bus.write_en = 1'b0;
        #1;
        chk(tag, bus.read_data, exp);
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 2 * FRAME && (m_phase % FRAME) != target; i++) idle(1);
        chk("phase_sync", 32'(m_phase % FRAME), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int r;
        bus.addr_i = '0; bus.write_data = '0; bus.write_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Run briefly, then reset asynchronously mid-operation.
        wr(2, 32'h5A); wr(0, 32'h0003_0001);
        idle(37);
        rst = 1'b1;
        #1;
        chk("rst_row_sel", 32'(row_sel), 32'h0);
        chk("rst_col_out", 32'(col_out), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        peek("ctrl_after_rst", 0, 32'h0);
        peek("status_after_rst", 1, 32'h0);
        peek("row0_after_rst", 2, 32'h0);

        // Straight-through buffers, full brightness.
        wr(2, 32'h01); wr(3, 32'h02); wr(4, 32'h04); wr(5, 32'h08);
        wr(0, 32'h0003_0001);
        idle(100);

        // Double buffering, including a write on the frame-end cycle.
        wr(0, 32'h0003_0003);
        wait_phase(5);
        wr(3, 32'hFF);
        peek("pend_set", 1, {m_frames, 8'(cur_row()), 8'h01});
        idle(80);
        wait_phase(FRAME - 1);
        wr(4, 32'hAA);
        peek("pend_kept_at_frame_end", 1, {m_frames, 8'd0, 8'h01});
        idle(2 * FRAME + 4);
        peek("pend_cleared", 1, {m_frames, 8'(cur_row()), 8'h00});

        // Brightness 1 and 0.
        wr(0, 32'h0001_0003);
        idle(40);
        wr(0, 32'h0000_0003);
        idle(40);

        // Blink every 2 frames, then off.
        wr(0, 32'h0003_0203);
        idle(6 * FRAME);
        wr(0, 32'h0003_0003);
        idle(4);
        peek("blink_off_cleared", 1, {m_frames, 8'(cur_row()), 8'h00});

        // Disable in the middle of row 2, then re-enable.
        wait_phase(2 * DWELL + 3);
        wr(0, 32'h0003_0002);
        idle(1);
        chk("row_sel_after_disable", 32'(row_sel), 32'h0);
        chk("col_out_after_disable", 32'(col_out), 32'h0);
        peek("status_row_after_disable", 1, {m_frames, 8'd0, 8'h00});
        idle(5);
        wr(1, 32'hFFFF_FFFF);
        peek("offset15_reads_zero", 15, 32'h0);
        wr(0, 32'h0003_0003);
        idle(1);
        chk("restart_row0", 32'(row_sel), 32'h1);
        idle(40);

        // Randomized register traffic.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 9) != 0);
                d[15:8] = 8'($urandom_range(0, 3));
                wr(0, d);
            end else if (r < 4) begin
                wr(int'($urandom_range(2, 1 + ROWS)), $urandom);
            end else if (r == 4) begin
                wr(int'($urandom_range(0, 1)) == 0 ? 1 : int'($urandom_range(2 + ROWS, 15)), $urandom);
            end else begin
                idle(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
